seq_alu: RTL and testbench
==========================

SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width; legal values 8..32.
REQ-002 input_CLK  in  1  single clock; all state updates on rising edge.
REQ-003 input_Reset_n  in  1  reset, asynchronous and active-low.
REQ-004 input_A, input_B  in  WIDTH  operands.
REQ-005 input_ALUOp  in  4  operation code.
REQ-006 input_Start  in  1  request; sampled only when output_Busy=0.
REQ-007 output_ALU  out  WIDTH  primary result (sum, product low half, quotient).
REQ-008 output_High  out  WIDTH  product high half / divide remainder; 0 for other ops.
REQ-009 output_Zero, output_Negative, output_Carry, output_Overflow  out  1 each  registered flags.
REQ-010 output_Busy  out  1  multi-cycle op in progress.
REQ-011 output_Done  out  1  one-cycle pulse: results and flags valid.
REQ-012 output_Error  out  1  last completed op was undefined opcode or divide-by-zero.

Function
REQ-013 FSM states IDLE, EXEC, DONE; IDLE/DONE with Start=1 accept op; EXEC ignores Start.
REQ-014 Operands and opcode latched at acceptance; later input changes have no effect on that op.
REQ-015 Single-cycle ops, results registered at acceptance edge, FSM->DONE, Done=1 for the following cycle: 0000 A+B, 0001 A-B, 0010 AND, 0011 OR, 0100 XOR, 0101 SLL, 0110 SRL, 0111 SLA (=SLL), 1000 SRA (sign-fill), 1001 2*(A+B) truncated, 1100 pass B.
REQ-016 Shift amount = input_B[clog2(WIDTH)-1:0]; shift by 0 returns A.
REQ-017 1010 unsigned multiply: shift-add, one bit per cycle, WIDTH EXEC cycles; Busy=1 throughout; Done one cycle after last iteration; output_ALU=low, output_High=high.
REQ-018 1011 unsigned divide: restoring, one bit per cycle, WIDTH EXEC cycles; output_ALU=quotient, output_High=remainder.
REQ-019 Divide with B=0: no EXEC; completes as single-cycle op, output_ALU=all ones, output_High=A, Error=1.
REQ-020 Undefined opcodes (1101,1110,1111): single-cycle, output_ALU=0, output_High=0, Error=1; all other ops Error=0.
REQ-021 Zero = (output_ALU==0); Negative = output_ALU[WIDTH-1].
REQ-022 Carry: add = carry-out; sub = borrow (A<B unsigned); shifts = last bit shifted out (0 if amount 0); 2*(A+B) = exact result >= 2^WIDTH; multiply = (high half != 0); else 0.
REQ-023 Overflow: signed overflow for add/sub; 0 for all other ops.
REQ-024 Results, flags, Error hold until next op completes; Done=0 otherwise.
REQ-025 Start held high in DONE accepts next op back-to-back; Done pulses once per op.
REQ-026 Latency: single-cycle op Done at cycle N+1 after acceptance edge N; mul/div Done at cycle N+WIDTH+1.

Reset
REQ-027 Reset_n=0 asynchronously forces IDLE, all outputs 0, iteration counter 0.
REQ-028 Reset asserted mid-EXEC aborts op; no Done pulse, no result update after release.
REQ-029 First Start sampled on first rising edge with Reset_n=1.

Verification
REQ-030 WIDTH=16, ADD A=FFFF B=0001 -> ALU=0000, Zero=1, Carry=1, Overflow=0, Done one cycle.
REQ-031 SUB A=7FFF... use A=8000 B=0001 -> ALU=7FFF, Overflow=1, Carry=0, Negative=0.
REQ-032 MUL A=FFFF B=FFFF -> Busy 16 cycles, Done at cycle 17, ALU=0001, High=FFFE, Carry=1.
REQ-033 DIV A=0064 B=0007 -> ALU=000E, High=0002; DIV B=0 -> ALU=FFFF, High=A, Error=1, Done next cycle, Busy never high.
REQ-034 MUL started, Start pulsed mid-EXEC with ADD, then Reset_n low at cycle 8 -> ADD ignored, no Done, all outputs 0.
REQ-035 Opcode 1110 -> ALU=0, Error=1; following ADD 0002+0003 back-to-back -> ALU=0005, Error=0, two distinct Done pulses.

Source files
------------

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/arith/shift ops plus shift-add multiply and
// restoring divide that iterate one bit per clock through a shared work register pair.
module seq_alu #(
  parameter int WIDTH = 16
) (
  input  logic             input_CLK,
  input  logic             input_Reset_n,
  input  logic [WIDTH-1:0] input_A,
  input  logic [WIDTH-1:0] input_B,
  input  logic [3:0]       input_ALUOp,
  input  logic             input_Start,
  output logic [WIDTH-1:0] output_ALU,
  output logic [WIDTH-1:0] output_High,
  output logic             output_Zero,
  output logic             output_Negative,
  output logic             output_Carry,
  output logic             output_Overflow,
  output logic             output_Busy,
  output logic             output_Done,
  output logic             output_Error
);

  localparam int SW = $clog2(WIDTH);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t           state, nxt_state;
  logic [CW-1:0]    cnt;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] op_b, work_hi, work_lo;

  logic accept, multi_op, last_iter;
  assign accept    = input_Start && (state != EXEC);
  assign multi_op  = (input_ALUOp == 4'b1010) || (input_ALUOp == 4'b1011 && input_B != '0);
  assign last_iter = (cnt == CW'(WIDTH-1));

  // FSM: state register
  always_ff @(posedge input_CLK or negedge input_Reset_n)
    if (!input_Reset_n) state <= IDLE;
    else                state <= nxt_state;

  // FSM: next state
  always_comb begin
    nxt_state = state;
    case (state)
      IDLE, DONE: nxt_state = input_Start ? (multi_op ? EXEC : DONE) : IDLE;
      EXEC:       nxt_state = last_iter ? DONE : EXEC;
      default:    nxt_state = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    output_Busy = (state == EXEC);
    output_Done = (state == DONE);
  end

  // Single-cycle results, evaluated on the live inputs at the acceptance edge
  logic [SW-1:0]    sh;
  logic [WIDTH:0]   sum, diff, shl, shr, sra;
  logic [WIDTH-1:0] res_alu, res_high;
  logic             res_c, res_v, res_err;

  always_comb begin
    sh       = input_B[SW-1:0];
    sum      = {1'b0, input_A} + {1'b0, input_B};
    diff     = {1'b0, input_A} - {1'b0, input_B};
    shl      = {1'b0, input_A} << sh;
    shr      = {input_A, 1'b0} >> sh;
    sra      = $signed({input_A, 1'b0}) >>> sh;
    res_alu  = '0;
    res_high = '0;
    res_c    = 1'b0;
    res_v    = 1'b0;
    res_err  = 1'b0;
    case (input_ALUOp)
      4'b0000: begin
        res_alu = sum[WIDTH-1:0];
        res_c   = sum[WIDTH];
        res_v   = (input_A[WIDTH-1] == input_B[WIDTH-1]) && (sum[WIDTH-1] != input_A[WIDTH-1]);
      end
      4'b0001: begin
        res_alu = diff[WIDTH-1:0];
        res_c   = diff[WIDTH];
        res_v   = (input_A[WIDTH-1] != input_B[WIDTH-1]) && (diff[WIDTH-1] != input_A[WIDTH-1]);
      end
      4'b0010: res_alu = input_A & input_B;
      4'b0011: res_alu = input_A | input_B;
      4'b0100: res_alu = input_A ^ input_B;
      4'b0101, 4'b0111: begin res_alu = shl[WIDTH-1:0]; res_c = shl[WIDTH]; end
      4'b0110: begin res_alu = shr[WIDTH:1]; res_c = shr[0]; end
      4'b1000: begin res_alu = sra[WIDTH:1]; res_c = sra[0]; end
      // 2*(A+B) overflows the result iff either of the top two sum bits is set
      4'b1001: begin
        res_alu = {sum[WIDTH-2:0], 1'b0};
        res_c   = sum[WIDTH] | sum[WIDTH-1];
      end
      4'b1010: ;
      4'b1011: begin res_alu = '1; res_high = input_A; res_err = 1'b1; end
      4'b1100: res_alu = input_B;
      default: res_err = 1'b1;
    endcase
  end

  // One multiply or divide iteration; work_hi holds high half / remainder
  logic [WIDTH:0]   mul_sum, div_r;
  logic [WIDTH-1:0] div_t, nx_hi, nx_lo;
  logic             div_ge;

  always_comb begin
    mul_sum = {1'b0, work_hi} + (work_lo[0] ? {1'b0, op_b} : '0);
    div_r   = {work_hi, work_lo[WIDTH-1]};
    div_ge  = div_r >= {1'b0, op_b};
    div_t   = div_r[WIDTH-1:0] - op_b;
    if (op_q == 4'b1010) begin
      nx_hi = mul_sum[WIDTH:1];
      nx_lo = {mul_sum[0], work_lo[WIDTH-1:1]};
    end else begin
      nx_hi = div_ge ? div_t : div_r[WIDTH-1:0];
      nx_lo = {work_lo[WIDTH-2:0], div_ge};
    end
  end

  always_ff @(posedge input_CLK or negedge input_Reset_n)
    if (!input_Reset_n) begin
      cnt             <= '0;
      op_q            <= '0;
      op_b            <= '0;
      work_hi         <= '0;
      work_lo         <= '0;
      output_ALU      <= '0;
      output_High     <= '0;
      output_Zero     <= 1'b0;
      output_Negative <= 1'b0;
      output_Carry    <= 1'b0;
      output_Overflow <= 1'b0;
      output_Error    <= 1'b0;
    end else if (accept) begin
      op_q <= input_ALUOp;
      op_b <= input_B;
      cnt  <= '0;
      if (multi_op) begin
        work_hi <= '0;
        work_lo <= input_A;
      end else begin
        output_ALU      <= res_alu;
        output_High     <= res_high;
        output_Zero     <= (res_alu == '0);
        output_Negative <= res_alu[WIDTH-1];
        output_Carry    <= res_c;
        output_Overflow <= res_v;
        output_Error    <= res_err;
      end
    end else if (state == EXEC) begin
      work_hi <= nx_hi;
      work_lo <= nx_lo;
      cnt     <= cnt + 1'b1;
      if (last_iter) begin
        output_ALU      <= nx_lo;
        output_High     <= nx_hi;
        output_Zero     <= (nx_lo == '0);
        output_Negative <= nx_lo[WIDTH-1];
        output_Carry    <= (op_q == 4'b1010) && (nx_hi != '0);
        output_Overflow <= 1'b0;
        output_Error    <= 1'b0;
      end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Directed + random bench for seq_alu (WIDTH=16): reference-model scoreboard popped on Done.
module tb_seq_alu;
  localparam int W = 16;

  logic         clk, rst_n, start;
  logic [W-1:0] a, b, alu, high;
  logic [3:0]   op;
  logic         zero, neg, carry, ovf, busy, done, err;

  seq_alu #(.WIDTH(W)) dut (
    .input_CLK(clk), .input_Reset_n(rst_n), .input_A(a), .input_B(b),
    .input_ALUOp(op), .input_Start(start), .output_ALU(alu), .output_High(high),
    .output_Zero(zero), .output_Negative(neg), .output_Carry(carry),
    .output_Overflow(ovf), .output_Busy(busy), .output_Done(done), .output_Error(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0, failures = 0, done_cnt = 0;
  logic [36:0] sb[$];
  logic [36:0] last_exp;

  // {alu, high, zero, neg, carry, ovf, err}
  function automatic logic [36:0] model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] r, h;
    logic c, v, e;
    logic [16:0] s;
    logic [17:0] t;
    logic [31:0] p;
    int sh;
    r = '0; h = '0; c = 0; v = 0; e = 0;
    sh = int'(y[3:0]);
    case (o)
      4'd0: begin s = {1'b0, x} + {1'b0, y}; r = s[15:0]; c = s[16];
                  v = (x[15] == y[15]) && (r[15] != x[15]); end
      4'd1: begin r = x - y; c = (x < y); v = (x[15] != y[15]) && (r[15] != x[15]); end
      4'd2: r = x & y;
      4'd3: r = x | y;
      4'd4: r = x ^ y;
      4'd5, 4'd7: begin r = x << sh; c = (sh != 0) ? x[16-sh] : 1'b0; end
      4'd6: begin r = x >> sh; c = (sh != 0) ? x[sh-1] : 1'b0; end
      4'd8: begin r = $signed(x) >>> sh; c = (sh != 0) ? x[sh-1] : 1'b0; end
      4'd9: begin t = 18'(x) + 18'(y); t = t * 2; r = t[15:0]; c = (t >= 18'd65536); end
      4'd10: begin p = 32'(x) * 32'(y); r = p[15:0]; h = p[31:16]; c = (h != 0); end
      4'd11: if (y == 0) begin r = '1; h = x; e = 1; end
             else begin r = x / y; h = x % y; end
      4'd12: r = y;
      default: e = 1;
    endcase
    return {r, h, (r == 0), r[15], c, v, e};
  endfunction

  // Scoreboard: every Done cycle must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst_n && done) begin
      checks++;
      done_cnt++;
      assert (sb.size() != 0) else begin
        failures++;
        $error("FAIL done_unexpected got=%h expected=none", {alu, high, zero, neg, carry, ovf, err});
      end
      if (sb.size() != 0) begin
        last_exp = sb.pop_front();
        assert ({alu, high, zero, neg, carry, ovf, err} === last_exp) else begin
          failures++;
          $error("FAIL result got=%h expected=%h", {alu, high, zero, neg, carry, ovf, err}, last_exp);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Call at posedge+1; returns at posedge+1 of the first Done cycle with Start low
  task automatic do_op(input string tag, input logic [3:0] o, input logic [W-1:0] x,
                       input logic [W-1:0] y, input int exp_lat, input int exp_busy);
    int lat, nbusy;
    op = o; a = x; b = y; start = 1'b1;
    sb.push_back(model(o, x, y));
    @(posedge clk); #1;
    start = 1'b0;
    a = ~x; b = ~y; op = ~o;
    lat = 1; nbusy = 0;
    while (!done && lat < 40) begin
      if (busy) nbusy++;
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_busy_cycles"}, 64'(nbusy), 64'(exp_busy));
  endtask

  initial begin
    logic [3:0] ro;
    logic [W-1:0] ra, rb;
    int d0;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; op = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", 64'({alu, high, zero, neg, carry, ovf, busy, done, err}), 64'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op("add_wrap", 4'd0, 16'hFFFF, 16'h0001, 1, 0);
    do_op("sub_ovf", 4'd1, 16'h8000, 16'h0001, 1, 0);
    do_op("mul_max", 4'd10, 16'hFFFF, 16'hFFFF, 17, 16);
    do_op("div_100_7", 4'd11, 16'h0064, 16'h0007, 17, 16);
    do_op("div_zero", 4'd11, 16'h1234, 16'h0000, 1, 0);
    do_op("sll_1", 4'd5, 16'h8001, 16'h0001, 1, 0);
    do_op("srl_0", 4'd6, 16'h8001, 16'h0010, 1, 0);
    do_op("sra_4", 4'd8, 16'h8018, 16'h0004, 1, 0);
    do_op("sla_15", 4'd7, 16'h0003, 16'h000F, 1, 0);
    do_op("dbl_carry", 4'd9, 16'h8000, 16'h0000, 1, 0);
    do_op("pass_b", 4'd12, 16'h1111, 16'hC0DE, 1, 0);
    do_op("xor", 4'd4, 16'hA5A5, 16'hA5A5, 1, 0);

    // results must hold while idle
    repeat (3) @(posedge clk);
    #1;
    chk("hold_results", 64'({alu, high, zero, neg, carry, ovf, err, done}), 64'({last_exp, 1'b0}));

    // undefined opcode, then ADD accepted from DONE with Start held
    d0 = done_cnt;
    op = 4'd14; a = 16'h7777; b = 16'h1; start = 1'b1;
    sb.push_back(model(4'd14, 16'h7777, 16'h1));
    @(posedge clk); #1;
    chk("undef_err", 64'({alu, err, done}), 64'({16'h0, 1'b1, 1'b1}));
    op = 4'd0; a = 16'h0002; b = 16'h0003;
    sb.push_back(model(4'd0, 16'h0002, 16'h0003));
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_add", 64'({alu, err, done}), 64'({16'h0005, 1'b0, 1'b1}));
    @(posedge clk); #1;
    chk("b2b_two_dones", 64'(done_cnt - d0), 64'(2));

    for (int i = 0; i < 30; i++) begin
      ro = 4'($urandom_range(0, 15));
      ra = 16'($urandom);
      rb = (i % 7 == 0) ? 16'h0 : 16'($urandom);
      do_op("rand", ro, ra, rb, (ro == 4'd10 || (ro == 4'd11 && rb != 0)) ? 17 : 1,
            (ro == 4'd10 || (ro == 4'd11 && rb != 0)) ? 16 : 0);
    end
    @(posedge clk); #1;
    chk("sb_drained", 64'(sb.size()), 64'(0));

    // multiply aborted by reset; mid-EXEC Start must be ignored
    d0 = done_cnt;
    op = 4'd10; a = 16'h1234; b = 16'h5678; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    op = 4'd0; a = 16'h0001; b = 16'h0001; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("exec_ignores_start", 64'({busy, done}), 64'({1'b1, 1'b0}));
    rst_n = 1'b0;
    #1;
    chk("abort_outputs_zero", 64'({alu, high, zero, neg, carry, ovf, busy, done, err}), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("abort_no_update", 64'({alu, high, zero, neg, carry, ovf, busy, done, err}), 64'(0));
    chk("abort_no_done", 64'(done_cnt - d0), 64'(0));

    // first edge after release accepts
    do_op("post_reset_or", 4'd3, 16'hF000, 16'h000F, 1, 0);
    @(posedge clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
